// File: rtl/sensor_frame_tx_ctrl.sv
// Sensor frame transmitter: packs each 32-bit sample into a 6-byte frame
// (header, 4 data bytes, additive checksum) and feeds it byte-wise to a UART.
module sensor_frame_tx_ctrl #(
  parameter logic [7:0]  HEADER     = 8'hAA,
  parameter logic [15:0] FRAME_GAP  = 16'd1000,
  parameter logic [19:0] TX_TIMEOUT = 20'd100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        sample_valid,
  input  logic [31:0] sample_data,
  input  logic        tx_done,
  output logic [7:0]  tx_data,
  output logic        tx_start,
  output logic        busy,
  output logic        frame_done,
  output logic        timeout_err,
  output logic [7:0]  drop_cnt,
  output logic [1:0]  state_dbg
);

  // UART handshake: tx_start is a one-cycle request and tx_data is held
  // stable until the UART answers with a one-cycle tx_done; tx_done is only
  // honoured while waiting for it.
  typedef enum logic [1:0] {IDLE, SEND, WAIT, GAP} state_t;

  state_t      state, state_nxt;
  logic [31:0] pend_word;
  logic [31:0] frame_word;
  logic        pend_flag;
  logic [7:0]  chk;
  logic [7:0]  chk_calc;
  logic [2:0]  byte_idx;
  logic [19:0] tmo_cnt;
  logic [15:0] gap_cnt;
  logic        consume;
  logic        last_byte;
  logic        tmo_hit;
  logic        gap_end;

  function automatic logic [7:0] sel_byte(input logic [2:0] idx,
                                          input logic [31:0] w,
                                          input logic [7:0] c);
    case (idx)
      3'd0:    sel_byte = HEADER;
      3'd1:    sel_byte = w[31:24];
      3'd2:    sel_byte = w[23:16];
      3'd3:    sel_byte = w[15:8];
      3'd4:    sel_byte = w[7:0];
      3'd5:    sel_byte = c;
      default: sel_byte = 8'h00;
    endcase
  endfunction

  always_comb begin
    consume   = (state == IDLE) && pend_flag && enable;
    last_byte = (byte_idx == 3'd5);
    // tx_done on the terminal count still counts as success
    tmo_hit   = (state == WAIT) && !tx_done && (tmo_cnt == TX_TIMEOUT - 20'd1);
    gap_end   = (state == GAP) && (gap_cnt == FRAME_GAP - 16'd1);
    chk_calc  = pend_word[31:24] + pend_word[23:16] + pend_word[15:8] + pend_word[7:0];

    state_nxt = state;
    case (state)
      IDLE: if (consume) state_nxt = SEND;
      SEND: state_nxt = WAIT;
      WAIT: begin
        if (tx_done)      state_nxt = last_byte ? GAP : SEND;
        else if (tmo_hit) state_nxt = GAP;
      end
      GAP:  if (gap_end) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_word   <= 32'h0;
      pend_flag   <= 1'b0;
      drop_cnt    <= 8'h00;
      frame_word  <= 32'h0;
      chk         <= 8'h00;
      byte_idx    <= 3'd0;
      tx_data     <= 8'h00;
      timeout_err <= 1'b0;
      frame_done  <= 1'b0;
      tmo_cnt     <= 20'd0;
      gap_cnt     <= 16'd0;
    end else begin
      frame_done <= 1'b0;

      // A sample arriving in the consume cycle refills the slot without a drop
      if (sample_valid) begin
        pend_word <= sample_data;
        pend_flag <= 1'b1;
        if (pend_flag && !consume && drop_cnt != 8'hFF)
          drop_cnt <= drop_cnt + 8'd1;
      end else if (consume) begin
        pend_flag <= 1'b0;
      end

      if (consume) begin
        frame_word  <= pend_word;
        chk         <= chk_calc;
        byte_idx    <= 3'd0;
        tx_data     <= HEADER;
        timeout_err <= 1'b0;
      end

      if (state == SEND) tmo_cnt <= 20'd0;

      if (state == WAIT) begin
        if (tx_done) begin
          if (last_byte) begin
            frame_done <= 1'b1;
          end else begin
            byte_idx <= byte_idx + 3'd1;
            tx_data  <= sel_byte(byte_idx + 3'd1, frame_word, chk);
          end
        end else if (tmo_hit) begin
          timeout_err <= 1'b1;
        end else begin
          tmo_cnt <= tmo_cnt + 20'd1;
        end
      end

      if (state == WAIT && state_nxt == GAP) gap_cnt <= 16'd0;
      else if (state == GAP)                 gap_cnt <= gap_cnt + 16'd1;
    end
  end

  assign tx_start  = (state == SEND);
  assign busy      = (state != IDLE);
  assign state_dbg = state;

endmodule

// File: tb/tb_sensor_frame_tx_ctrl.sv
// Bench for sensor_frame_tx_ctrl: UART responder, frame-level reference model
// feeding an expected-byte queue, and a monitor that checks every tx_start.
module tb_sensor_frame_tx_ctrl;

  localparam int GAP_C = 30;
  localparam int TMO_C = 200;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        sample_valid;
  logic [31:0] sample_data;
  logic        tx_done;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        busy;
  logic        frame_done;
  logic        timeout_err;
  logic [7:0]  drop_cnt;
  logic [1:0]  state_dbg;

  sensor_frame_tx_ctrl #(
    .HEADER    (8'hAA),
    .FRAME_GAP (16'd30),
    .TX_TIMEOUT(20'd200)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .sample_valid(sample_valid),
    .sample_data (sample_data),
    .tx_done     (tx_done),
    .tx_data     (tx_data),
    .tx_start    (tx_start),
    .busy        (busy),
    .frame_done  (frame_done),
    .timeout_err (timeout_err),
    .drop_cnt    (drop_cnt),
    .state_dbg   (state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  logic [7:0] exp_q[$];
  int n_checks = 0;
  int n_fail = 0;
  int exp_drop = 0;
  int exp_fd = 0;
  int n_fd = 0;
  int bytes_sent = 0;
  int withhold_at = 0;
  int done_delay = 1;
  int last_start_cyc = 0;
  int last_done_cyc = 0;
  logic in_flight = 1'b0;
  logic [7:0] held_byte = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: a sample becomes header, its four bytes MSB first, and
  // the mod-256 sum of those four bytes.
  function automatic void push_frame(input logic [31:0] w, input int nbytes);
    logic [7:0] b[6];
    b[0] = 8'hAA;
    b[1] = w[31:24];
    b[2] = w[23:16];
    b[3] = w[15:8];
    b[4] = w[7:0];
    b[5] = 8'((int'(b[1]) + int'(b[2]) + int'(b[3]) + int'(b[4])) % 256);
    for (int i = 0; i < nbytes; i++) exp_q.push_back(b[i]);
    if (nbytes == 6) exp_fd++;
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [7:0] eb;
    if (tx_start) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_tx_start: got tx_data 0x%0h with no byte expected (cycle %0d)",
                 tx_data, cyc);
      end else begin
        eb = exp_q.pop_front();
        check("tx_data", tx_data, eb);
      end
      held_byte = tx_data;
      in_flight = 1'b1;
    end
    if (tx_done && in_flight) begin
      check("tx_data_hold", tx_data, held_byte);
      in_flight = 1'b0;
      last_done_cyc = cyc;
    end
    if (frame_done) begin
      n_fd++;
      check("frame_done_latency", cyc, last_done_cyc + 1);
    end
  end

  // ---------------- UART responder ----------------
  initial begin
    tx_done = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_start) begin
        bytes_sent++;
        last_start_cyc = cyc;
        if (bytes_sent != withhold_at) begin
          repeat (done_delay) @(posedge clk);
          #1 tx_done = 1'b1;
          @(posedge clk);
          #1 tx_done = 1'b0;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    in_flight = 1'b0;
    exp_drop = 0;
    exp_fd = 0;
    n_fd = 0;
    bytes_sent = 0;
    withhold_at = 0;
  endtask

  task automatic send_sample(input logic [31:0] w);
    sample_valid = 1'b1;
    sample_data = w;
    tick();
    sample_valid = 1'b0;
  endtask

  task automatic wait_quiet(input string name, input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < budget) begin
      tick();
      n++;
    end
    check(name, (exp_q.size() == 0 && !busy), 1);
  endtask

  task automatic wait_frame_done(input string name, input int budget);
    int n = 0;
    while (!frame_done && n < budget) begin
      tick();
      n++;
    end
    check(name, frame_done, 1);
  endtask

  task automatic wait_bytes(input string name, input int nb, input int budget);
    int n = 0;
    while (bytes_sent < nb && n < budget) begin
      tick();
      n++;
    end
    check(name, bytes_sent, nb);
  endtask

  task automatic measure_busy(input string name, input int expect_len);
    int n = 0;
    while (busy && n < 5000) begin
      tick();
      n++;
    end
    check(name, n, expect_len);
  endtask

  task automatic end_checks(input string name);
    check({name, "_drop_cnt"}, drop_cnt, exp_drop);
    check({name, "_frame_done_count"}, n_fd, exp_fd);
    check({name, "_queue_empty"}, exp_q.size(), 0);
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_tx_start"}, tx_start, 0);
    check({name, "_busy"}, busy, 0);
    check({name, "_tx_data"}, tx_data, 0);
    check({name, "_drop_cnt"}, drop_cnt, 0);
    check({name, "_timeout_err"}, timeout_err, 0);
    check({name, "_frame_done"}, frame_done, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] w, last;
    int k;
    rst = 1'b1;
    enable = 1'b0;
    sample_valid = 1'b0;
    sample_data = 32'h0;

    // Single known frame, latency, frame_done timing and gap length
    do_reset();
    check_reset_outputs("reset");
    enable = 1'b1;
    done_delay = 20;
    exp_q.push_back(8'hAA); exp_q.push_back(8'h02); exp_q.push_back(8'h58);
    exp_q.push_back(8'h00); exp_q.push_back(8'hFA); exp_q.push_back(8'h54);
    exp_fd = 1;
    send_sample(32'h0258_00FA);
    check("latency_n1_tx_start", tx_start, 0);
    check("latency_n1_busy", busy, 0);
    tick();
    check("latency_n2_tx_start", tx_start, 1);
    check("latency_n2_header", tx_data, 8'hAA);
    wait_frame_done("single_frame_done", 1000);
    measure_busy("single_gap_len", GAP_C);
    end_checks("single");

    // Overwrite during a frame; enable dropped mid-frame does not abort it
    do_reset();
    enable = 1'b1;
    done_delay = 5;
    push_frame(32'h1122_3344, 6);
    send_sample(32'h1122_3344);
    repeat (4) tick();
    send_sample(32'hDEAD_BEEF);
    tick();
    send_sample(32'hCAFE_0123);
    push_frame(32'hCAFE_0123, 6);
    exp_drop = 1;
    enable = 1'b0;
    wait_frame_done("overwrite_first_done", 1000);
    measure_busy("overwrite_gap_len", GAP_C);
    repeat (10) tick();
    check("overwrite_blocked_busy", busy, 0);
    enable = 1'b1;
    wait_quiet("overwrite_quiet", 2000);
    end_checks("overwrite");

    // Timeout after the third byte, then a clean frame clears the error
    do_reset();
    enable = 1'b1;
    done_delay = 3;
    withhold_at = 3;
    push_frame(32'h5566_7788, 3);
    send_sample(32'h5566_7788);
    wait_bytes("timeout_bytes", 3, 500);
    while (cyc < last_start_cyc + TMO_C) tick();
    check("timeout_before_err", timeout_err, 0);
    check("timeout_before_busy", busy, 1);
    tick();
    check("timeout_err_set", timeout_err, 1);
    check("timeout_no_frame_done", frame_done, 0);
    measure_busy("timeout_gap_len", GAP_C);
    withhold_at = 0;
    push_frame(32'h0102_0304, 6);
    send_sample(32'h0102_0304);
    check("timeout_err_sticky", timeout_err, 1);
    tick();
    check("timeout_restart_tx_start", tx_start, 1);
    check("timeout_restart_header", tx_data, 8'hAA);
    check("timeout_err_cleared", timeout_err, 0);
    wait_quiet("timeout_quiet", 2000);
    end_checks("timeout");

    // Reset during the fourth byte's wait; pending sample is lost
    do_reset();
    enable = 1'b1;
    done_delay = 20;
    push_frame(32'h99AA_BBCC, 4);
    send_sample(32'h99AA_BBCC);
    wait_bytes("reset_first_byte", 1, 200);
    send_sample(32'h7777_7777);
    wait_bytes("reset_fourth_byte", 4, 500);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    in_flight = 1'b0;
    check_reset_outputs("mid_reset");
    repeat (40) tick();
    check("mid_reset_idle", busy, 0);
    exp_drop = 0;
    end_checks("mid_reset");

    // Enable gating plus sample arriving in the consume cycle
    do_reset();
    enable = 1'b0;
    send_sample(32'hA5A5_0F0F);
    repeat (20) tick();
    check("enable_gate_busy", busy, 0);
    done_delay = 2;
    push_frame(32'hA5A5_0F0F, 6);
    push_frame(32'h3C3C_F0F0, 6);
    enable = 1'b1;
    sample_valid = 1'b1;
    sample_data = 32'h3C3C_F0F0;
    tick();
    sample_valid = 1'b0;
    check("enable_header_tx_start", tx_start, 1);
    check("enable_header_data", tx_data, 8'hAA);
    wait_quiet("simul_quiet", 2000);
    end_checks("simul");

    // Drop counter saturation
    do_reset();
    enable = 1'b0;
    sample_valid = 1'b1;
    for (int i = 0; i < 255; i++) begin
      sample_data = $urandom;
      tick();
    end
    check("drop_cnt_254", drop_cnt, 254);
    for (int i = 0; i < 46; i++) begin
      sample_data = $urandom;
      tick();
    end
    sample_valid = 1'b0;
    check("drop_cnt_saturated", drop_cnt, 255);

    // Randomized frames with random UART latency and 0..3 extra samples
    do_reset();
    enable = 1'b1;
    for (int it = 0; it < 12; it++) begin
      w = $urandom;
      done_delay = $urandom_range(1, 20);
      push_frame(w, 6);
      send_sample(w);
      repeat (3) tick();
      k = $urandom_range(0, 3);
      last = 32'h0;
      for (int j = 0; j < k; j++) begin
        last = $urandom;
        send_sample(last);
        tick();
      end
      if (k > 0) begin
        push_frame(last, 6);
        exp_drop += k - 1;
      end
      wait_quiet("random_quiet", 3000);
    end
    end_checks("random");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sensor_frame_tx_ctrl.md
SENSOR_FRAME_TX_CTRL -- requirements
Module: sensor_frame_tx_ctrl

Interface
REQ-001 Parameters (name, default, meaning), one per line:
  HEADER      8'hAA     first byte of every frame
  FRAME_GAP   16'd1000  idle cycles enforced after each frame, completed or aborted
  TX_TIMEOUT  20'd100000  max cycles from tx_start to tx_done before the frame aborts
REQ-002 Ports (name, direction, width, meaning), one per line:
  clk            in   1   system clock; the block's only clock
  rst            in   1   synchronous, active-high reset
  enable         in   1   1 = new frames may start
  sample_valid   in   1   one-cycle pulse; sample_data valid this cycle
  sample_data    in   32  sensor word {hum[15:0], tem[15:0]}
  tx_done        in   1   one-cycle pulse from the UART when the current byte has finished shifting out
  tx_data        out  8   byte for the UART
  tx_start       out  1   one-cycle pulse requesting transmission of tx_data
  busy           out  1   1 whenever state is not IDLE
  frame_done     out  1   one-cycle pulse when a frame completes normally
  timeout_err    out  1   sticky abort flag
  drop_cnt       out  8   count of overwritten samples, saturating

Function
REQ-003 Frame SHALL be 6 bytes in this order: HEADER, sample[31:24], sample[23:16], sample[15:8], sample[7:0], CHK.
REQ-004 CHK SHALL be the mod-256 sum of the 4 data bytes; HEADER is excluded.
REQ-005 A one-deep pending register SHALL capture sample_data on every sample_valid and set pend_flag.
REQ-006 sample_valid while pend_flag=1 and the pending word is not being consumed that cycle SHALL overwrite the pending word and increment drop_cnt, saturating at 255.
REQ-007 States SHALL be IDLE, SEND, WAIT, GAP.
REQ-008 IDLE -> SEND when pend_flag=1 and enable=1, with these actions on that transition:
  - frame latched from the pending register
  - CHK computed
  - byte_idx=0
  - pend_flag cleared
REQ-009 sample_valid in the same cycle as the REQ-008 consumption SHALL leave pend_flag=1 holding the new word, with no drop counted.
REQ-010 SEND SHALL last exactly one cycle with tx_start=1 and tx_data=byte[byte_idx], then go to WAIT.
REQ-011 tx_data SHALL hold its value from tx_start until the matching tx_done.
REQ-012 WAIT on tx_done with byte_idx<5 SHALL increment byte_idx and go to SEND; the next tx_start is therefore exactly 1 cycle after tx_done.
REQ-013 WAIT on tx_done with byte_idx=5 SHALL pulse frame_done for 1 cycle and go to GAP.
REQ-014 The WAIT timeout counter SHALL clear on entry to WAIT.
REQ-015 If the timeout counter reaches TX_TIMEOUT-1 without tx_done, the block SHALL go to GAP and set timeout_err=1, with no frame_done and the remaining bytes discarded.
REQ-016 timeout_err SHALL clear only on rst or on the next REQ-008 frame start.
REQ-017 GAP SHALL last exactly FRAME_GAP cycles and then go to IDLE; samples arriving during GAP wait in the pending register.
REQ-018 tx_done outside WAIT SHALL be ignored.
REQ-019 tx_done in the same cycle as the timeout terminal count SHALL count as success (tx_done wins).
REQ-020 Deasserting enable mid-frame SHALL NOT abort the frame; it only blocks the next REQ-008 transition.
REQ-021 Latency SHALL be: sample_valid at cycle N with state IDLE and enable=1 gives pend_flag at N+1 and tx_start=1 with tx_data=HEADER at N+2.
REQ-022 busy SHALL be 1 in SEND, WAIT and GAP, and 0 in IDLE.

Reset
REQ-023 On rst=1 at a clock edge, the block SHALL reset as follows:
  - state = IDLE
  - tx_start, frame_done, busy, timeout_err = 0
  - tx_data = 8'h00
  - drop_cnt = 0
  - pend_flag = 0; pending word = 0
  - byte_idx and all counters = 0
REQ-024 rst mid-frame SHALL abandon the frame immediately with no further tx_start, and the pending sample is lost.
REQ-025 rst SHALL take priority over all other inputs.

Verification
REQ-026 Single frame: enable=1, sample 32'h0258_00FA, each tx_done returned 20 cycles after its tx_start -> bytes AA 02 58 00 FA 54; frame_done 1 cycle after the 6th tx_done; busy back to 0 after FRAME_GAP.
REQ-027 Overwrite: 3 samples A, B, C sent during one frame -> next frame carries C, drop_cnt=1.
REQ-028 Timeout: tx_done withheld after the 3rd byte -> timeout_err=1 at TX_TIMEOUT cycles, no frame_done, GAP entered; next frame starts with HEADER and timeout_err=0.
REQ-029 Reset mid-operation: rst during the 4th byte's WAIT -> all outputs at reset values next cycle; a later tx_done produces no tx_start.
REQ-030 Simultaneous consume: sample_valid in the REQ-008 consume cycle -> first frame = old word, second frame = new word, drop_cnt=0.
REQ-031 Enable gating and saturation:
  - enable=0 with sample pending -> no tx_start
  - enable=1 -> HEADER tx_start 1 cycle later
  - 300 overwrites -> drop_cnt=255
